st2mm_vdm_tx_packetizer: RTL and testbench
==========================================

Name: st2mm_vdm_tx_packetizer

Overview:
Host-side MCTP-over-PCIe VDM transmit engine behind the ST2MM TX registers: the FCR (offset 0x2000) and the TX data register (offset 0x2008).
- Host pushes message payload dwords into an internal FIFO through the TX data register.
- A write to the FCR with go=1 segments the message into one or more VDM TLPs with MCTP SOM/EOM/sequence fields.
- TLPs leave as a 32-bit valid/ready stream toward the PMCI VDM receive path.

Parameters:
- MAX_PLD_DW, 16, max payload dwords per TLP (MCTP baseline 64 B).
- FIFO_DEPTH, 512, payload FIFO depth in dwords (power of 2).
- REQ_ID, 16'h0000, requester ID placed in DW1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fcr_wr  in  1  FCR write strobe
- fcr_wdata  in  64  FCR write data
- fcr_rdata  out  64  FCR status readback
- txdr_wr  in  1  TX data register write strobe
- txdr_wdata  in  32  payload dword
- tx_valid  out  1  stream beat valid
- tx_ready  in  1  downstream accept
- tx_data  out  32  TLP dword
- tx_sop  out  1  first dword of TLP
- tx_eop  out  1  last dword of TLP

Behaviour:
- FCR write fields:
  - [9:0] len_dw; [23:16] dest EID; [31:24] src EID; [47:32] target ID; [50:48] msg tag; [51] TO.
  - [62] clr_err, write-1 clears all sticky errors.
  - [63] go.
- FCR read fields:
  - [0] busy; [1] fifo_full; [2] fifo_empty.
  - [3] len_err; [4] underrun_err; [5] overflow_err; [6] go_busy_err (all sticky).
  - [7] reserved, reads 0.
  - [17:8] reserved, reads 0.
  - [1+$clog2(FIFO_DEPTH)+31:32] fifo_count (10 bits, [41:32], for the default depth); remaining upper bits read 0.
- Reset values: tx_valid/sop/eop=0, tx_data=0, FIFO empty, pkt_seq=0, all errors 0, state IDLE.
- TX data writes:
  - Accepted in any state.
  - Write when full: dword dropped, overflow_err set.
- Go rules:
  - Go with len_dw==0 or len_dw>FIFO_DEPTH: len_err set, no output.
  - Go with len_dw>fifo_count: underrun_err set, no output, FIFO untouched.
  - Go while busy: ignored, go_busy_err set.
  - A write with both go and clr_err: clear happens first, then go is evaluated.
- FSM IDLE -> HDR -> PLD -> (HDR | IDLE):
  - IDLE: valid go latches the fields and rem=len_dw. First DW0 beat is valid 2 cycles after the fcr_wr cycle.
  - HDR: 4 beats, beat counter 0..3. pld=min(rem, MAX_PLD_DW).
    - DW0: fmt/type 8'h72 (Msg with data, routed by ID), TC/attr 0, length=pld.
    - DW1: REQ_ID, tag 0, msg code 8'h7F.
    - DW2: target ID, vendor ID 16'h1AB4.
    - DW3: MCTP hdr ver 4'h1, dest EID, src EID, SOM, EOM, pkt_seq[1:0], TO, tag.
    - SOM=1 only on the first TLP of a message; EOM=1 when rem==pld.
  - PLD: pops pld dwords, tx_eop on the last one. Then rem-=pld and pkt_seq increments mod 4. Go to HDR if rem>0, else IDLE.
- pkt_seq persists across messages; it is cleared only by reset.
- Handshake:
  - A beat transfers when tx_valid&&tx_ready.
  - While stalled, tx_data/sop/eop are held stable.
  - Full throughput at tx_ready=1 (FIFO read data is prefetched/registered).
- busy=1 from the accepted go until the final eop transfer.
- Reset mid-operation: all state cleared asynchronously, in-flight TLP abandoned (no eop), FIFO contents discarded.

Optional Feature:
- VDM_TX_TLP_DIGEST_EN defined:
  - Sets the TD bit in DW0.
  - Appends one ECRC-style dword after the payload: running XOR of all TLP dwords in that TLP. eop moves to the digest beat.
  - Length field is unchanged.
- Undefined: no digest beat, TD=0.

Decomposition:
- Package st2mm_vdm_tx_pkg:
  - FCR bit-position localparams.
  - State enum (IDLE, HDR, PLD).
  - Header constants: VDM_FMT_TYPE=8'h72, VDM_MSG_CODE=8'h7F, DMTF_VENDOR_ID=16'h1AB4, MCTP_HDR_VER=4'h1.
- One sub-module, st2mm_vdm_tx_fifo: synchronous FIFO with count, full/empty and registered show-ahead read.

Test Plan:
- Push 16 dwords (0x100+i), go len=16, dest EID 8'h08, src EID 8'h09, tag 3 -> one TLP of 20 beats. DW0 length=16; DW3 SOM=1, EOM=1, seq=0. Payload 0x100..0x10F in order.
- After reset, push 40 dwords, go len=40 -> 3 TLPs with lengths 16, 16, 8. SOM only on the first, EOM only on the last, seq 0, 1, 2. fifo_count ends at 0 with busy=0.
- Push 4 dwords, go len=10 -> no tx_valid, underrun_err=1, fifo_count=4. Then clr_err -> bit4=0.
- 40-dword message with random tx_ready (50%) -> tx_data/sop/eop stable during every stall and output identical to the stall-free run. Second go mid-message sets go_busy_err.
- 513 TX data writes with no go -> fifo_full=1, fifo_count=512, overflow_err=1.
- Assert rst during the second PLD beat -> tx_valid=0 in the same cycle, fifo_count=0, next message starts with seq 0.

Source files
------------

// File: rtl/st2mm_vdm_tx_pkg.sv
// Shared FCR field positions, FSM state type and VDM/MCTP header constants
// for the ST2MM VDM TX packetizer.
package st2mm_vdm_tx_pkg;

   // FCR write fields
   localparam int FCR_LEN_LSB  = 0;
   localparam int FCR_LEN_W    = 10;
   localparam int FCR_DEST_LSB = 16;
   localparam int FCR_SRC_LSB  = 24;
   localparam int FCR_TGT_LSB  = 32;
   localparam int FCR_TAG_LSB  = 48;
   localparam int FCR_TO_BIT   = 51;
   localparam int FCR_CLR_BIT  = 62;
   localparam int FCR_GO_BIT   = 63;

   // FCR read fields
   localparam int ST_BUSY     = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_EMPTY    = 2;
   localparam int ST_LEN_ERR  = 3;
   localparam int ST_UND_ERR  = 4;
   localparam int ST_OVF_ERR  = 5;
   localparam int ST_GOB_ERR  = 6;
   localparam int ST_CNT_LSB  = 32;

   localparam logic [7:0]  VDM_FMT_TYPE   = 8'h72;
   localparam logic [7:0]  VDM_MSG_CODE   = 8'h7F;
   localparam logic [15:0] DMTF_VENDOR_ID = 16'h1AB4;
   localparam logic [3:0]  MCTP_HDR_VER   = 4'h1;

   typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

   function automatic logic [31:0] mctp_dw3(input logic [7:0] dest, input logic [7:0] src,
                                            input logic som, input logic eom,
                                            input logic [1:0] seq, input logic to,
                                            input logic [2:0] tag);
      return {4'h0, MCTP_HDR_VER, dest, src, som, eom, seq, to, tag};
   endfunction

endpackage

// File: rtl/st2mm_vdm_tx_fifo.sv
// Payload FIFO with occupancy count and a registered show-ahead head word:
// rdata always holds the oldest entry while the FIFO is non-empty.
module st2mm_vdm_tx_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            wdata,
   input  logic                     pop,
   output logic [DW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
         // Next head comes from the write port when it is being written this very cycle
         if (do_pop)
            rdata <= (count == CW'(1)) ? wdata : mem[rd_ptr + AW'(1)];
         else if (empty && do_push)
            rdata <= wdata;
      end
   end

endmodule

// File: rtl/st2mm_vdm_tx_packetizer.sv
// MCTP-over-PCIe VDM TX engine: segments FIFO payload into VDM TLPs on a 32-bit stream.
// Define VDM_TX_TLP_DIGEST_EN to set TD and append an XOR digest dword per TLP.
module st2mm_vdm_tx_packetizer
   import st2mm_vdm_tx_pkg::*;
#(
   parameter int          MAX_PLD_DW = 16,
   parameter int          FIFO_DEPTH = 512,
   parameter logic [15:0] REQ_ID     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fcr_wr,
   input  logic [63:0] fcr_wdata,
   output logic [63:0] fcr_rdata,
   input  logic        txdr_wr,
   input  logic [31:0] txdr_wdata,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] tx_data,
   output logic        tx_sop,
   output logic        tx_eop
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef VDM_TX_TLP_DIGEST_EN
   localparam logic TD = 1'b1;
`else
   localparam logic TD = 1'b0;
`endif

   logic          fifo_pop, fifo_full, fifo_empty;
   logic [31:0]   fifo_rdata;
   logic [CW-1:0] fifo_count;

   st2mm_vdm_tx_fifo #(.DW(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (txdr_wr),
      .wdata (txdr_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   state_t      state;
   logic [1:0]  beat;
   logic [9:0]  cnt, rem, pld;
   logic        som_pend, to_r;
   logic [1:0]  seq;
   logic [7:0]  dest, src;
   logic [15:0] tgt;
   logic [2:0]  tag;
   logic        len_err, und_err, ovf_err, gob_err;

   logic       go, clr, busy, go_ok, set_len, set_und, set_gob;
   logic [9:0] go_len;
   logic       adv, load, nxt_ok, nxt_sop, nxt_eop;
   logic [31:0] nxt_data;
   logic       unused_fcr;

   assign go         = fcr_wr & fcr_wdata[FCR_GO_BIT];
   assign clr        = fcr_wr & fcr_wdata[FCR_CLR_BIT];
   assign go_len     = fcr_wdata[FCR_LEN_LSB +: FCR_LEN_W];
   assign busy       = (state != IDLE) | tx_valid;
   assign unused_fcr = ^{fcr_wdata[15:10], fcr_wdata[61:52]};

   always_comb begin
      go_ok   = 1'b0;
      set_len = 1'b0;
      set_und = 1'b0;
      set_gob = 1'b0;
      if (go) begin
         if (busy)                                                  set_gob = 1'b1;
         else if (go_len == '0 || int'(go_len) > FIFO_DEPTH)        set_len = 1'b1;
         else if (int'(go_len) > int'(fifo_count))                  set_und = 1'b1;
         else                                                       go_ok   = 1'b1;
      end
   end

   assign pld  = (int'(rem) > MAX_PLD_DW) ? 10'(MAX_PLD_DW) : rem;
   // Output register refills whenever it is empty or its beat is being taken
   assign adv  = ~tx_valid | tx_ready;
   assign load = adv & nxt_ok;

`ifdef VDM_TX_TLP_DIGEST_EN
   logic [31:0] digest;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       digest <= '0;
      else if (load) digest <= (nxt_sop ? 32'h0 : digest) ^ nxt_data;
   end
`endif

   always_comb begin
      nxt_ok   = 1'b0;
      nxt_sop  = 1'b0;
      nxt_eop  = 1'b0;
      nxt_data = '0;
      fifo_pop = 1'b0;
      case (state)
         HDR: begin
            nxt_ok = 1'b1;
            case (beat)
               2'd0: begin
                  nxt_sop  = 1'b1;
                  nxt_data = {VDM_FMT_TYPE, 8'h00, TD, 5'b0, pld};
               end
               2'd1:    nxt_data = {REQ_ID, 8'h00, VDM_MSG_CODE};
               2'd2:    nxt_data = {tgt, DMTF_VENDOR_ID};
               default: nxt_data = mctp_dw3(dest, src, som_pend, rem == pld, seq, to_r, tag);
            endcase
         end
         PLD: begin
            if (cnt != pld) begin
               nxt_ok   = ~fifo_empty;
               nxt_data = fifo_rdata;
`ifndef VDM_TX_TLP_DIGEST_EN
               nxt_eop  = (cnt == pld - 10'd1);
`endif
               fifo_pop = adv & ~fifo_empty;
            end
`ifdef VDM_TX_TLP_DIGEST_EN
            else begin
               nxt_ok   = 1'b1;
               nxt_eop  = 1'b1;
               nxt_data = digest;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_sop   <= 1'b0;
         tx_eop   <= 1'b0;
      end else if (adv) begin
         tx_valid <= nxt_ok;
         if (nxt_ok) begin
            tx_data <= nxt_data;
            tx_sop  <= nxt_sop;
            tx_eop  <= nxt_eop;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat     <= '0;
         cnt      <= '0;
         rem      <= '0;
         som_pend <= 1'b0;
         seq      <= '0;
         dest     <= '0;
         src      <= '0;
         tgt      <= '0;
         tag      <= '0;
         to_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (go_ok) begin
               rem      <= go_len;
               som_pend <= 1'b1;
               dest     <= fcr_wdata[FCR_DEST_LSB +: 8];
               src      <= fcr_wdata[FCR_SRC_LSB +: 8];
               tgt      <= fcr_wdata[FCR_TGT_LSB +: 16];
               tag      <= fcr_wdata[FCR_TAG_LSB +: 3];
               to_r     <= fcr_wdata[FCR_TO_BIT];
               beat     <= '0;
               state    <= HDR;
            end
            HDR: if (load) begin
               beat <= beat + 2'd1;
               if (beat == 2'd3) begin
                  cnt   <= '0;
                  state <= PLD;
               end
            end
            PLD: if (load) begin
               cnt <= cnt + 10'd1;
               if (nxt_eop) begin
                  rem      <= rem - pld;
                  seq      <= seq + 2'd1;
                  som_pend <= 1'b0;
                  state    <= (rem == pld) ? IDLE : HDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear is applied before this write's own go outcome is merged in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_err <= 1'b0;
         und_err <= 1'b0;
         ovf_err <= 1'b0;
         gob_err <= 1'b0;
      end else begin
         len_err <= (len_err & ~clr) | set_len;
         und_err <= (und_err & ~clr) | set_und;
         ovf_err <= (ovf_err & ~clr) | (txdr_wr & fifo_full);
         gob_err <= (gob_err & ~clr) | set_gob;
      end
   end

   always_comb begin
      fcr_rdata                    = '0;
      fcr_rdata[ST_BUSY]           = busy;
      fcr_rdata[ST_FULL]           = fifo_full;
      fcr_rdata[ST_EMPTY]          = fifo_empty;
      fcr_rdata[ST_LEN_ERR]        = len_err;
      fcr_rdata[ST_UND_ERR]        = und_err;
      fcr_rdata[ST_OVF_ERR]        = ovf_err;
      fcr_rdata[ST_GOB_ERR]        = gob_err;
      fcr_rdata[ST_CNT_LSB +: CW]  = fifo_count;
   end

endmodule

// File: tb/tb_st2mm_vdm_tx_packetizer.sv
// Randomized bench for st2mm_vdm_tx_packetizer against a message-level reference model.
module tb_st2mm_vdm_tx_packetizer;
`ifdef VDM_TX_TLP_DIGEST_EN
   localparam bit DIG = 1'b1;
`else
   localparam bit DIG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fcr_wr, txdr_wr;
   logic [63:0] fcr_wdata, fcr_rdata;
   logic [31:0] txdr_wdata, tx_data;
   logic        tx_valid, tx_sop, tx_eop;
   logic        tx_ready = 1'b1;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] mq[$];
   logic [33:0] expq[$], gotq[$];
   int          mseq = 0;
   bit          rand_rdy = 1'b0;

   always #5 clk = ~clk;

   st2mm_vdm_tx_packetizer dut (
      .clk(clk), .rst(rst), .fcr_wr(fcr_wr), .fcr_wdata(fcr_wdata), .fcr_rdata(fcr_rdata),
      .txdr_wr(txdr_wr), .txdr_wdata(txdr_wdata), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Collect transferred beats and check that stalled beats are held
   logic        prev_stall = 1'b0;
   logic [33:0] prev_beat;
   always @(negedge clk) begin
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("stall_vld", 64'(tx_valid), 64'd1);
            chk("stall_beat", 64'({tx_sop, tx_eop, tx_data}), 64'(prev_beat));
         end
         if (tx_valid && tx_ready) gotq.push_back({tx_sop, tx_eop, tx_data});
         prev_stall = tx_valid && !tx_ready;
         prev_beat  = {tx_sop, tx_eop, tx_data};
      end
   end

   function automatic logic [63:0] fcr(input int len, input logic [7:0] dest, input logic [7:0] src,
                                       input logic [15:0] tgt, input logic [2:0] tag, input logic to,
                                       input logic clr, input logic go);
      logic [63:0] w;
      w        = '0;
      w[9:0]   = len[9:0];
      w[23:16] = dest;
      w[31:24] = src;
      w[47:32] = tgt;
      w[50:48] = tag;
      w[51]    = to;
      w[62]    = clr;
      w[63]    = go;
      return w;
   endfunction

   task automatic push(input logic [31:0] d);
      txdr_wdata = d;
      txdr_wr    = 1'b1;
      @(posedge clk); #1;
      txdr_wr    = 1'b0;
      if (mq.size() < 512) mq.push_back(d);
   endtask

   task automatic fcr_write(input logic [63:0] d);
      fcr_wdata = d;
      fcr_wr    = 1'b1;
      @(posedge clk); #1;
      fcr_wr    = 1'b0;
   endtask

   // Expected beat stream of one accepted message, from the TLP/MCTP framing rules
   task automatic model_msg(input int len, input logic [7:0] dest, input logic [7:0] src,
                            input logic [15:0] tgt, input logic [2:0] tag, input logic to);
      int          rem, pld;
      logic        som;
      logic [31:0] hdr[4];
      logic [31:0] x, d;
      rem = len;
      som = 1'b1;
      while (rem > 0) begin
         pld    = (rem > 16) ? 16 : rem;
         hdr[0] = 32'h7200_0000 | 32'(pld) | (DIG ? 32'h8000 : 32'h0);
         hdr[1] = 32'h0000_007F;
         hdr[2] = {tgt, 16'h1AB4};
         hdr[3] = {8'h01, dest, src, som, rem == pld, 2'(mseq), to, tag};
         x = '0;
         for (int i = 0; i < 4; i++) begin
            expq.push_back({i == 0, 1'b0, hdr[i]});
            x ^= hdr[i];
         end
         for (int i = 0; i < pld; i++) begin
            d = mq.pop_front();
            x ^= d;
            expq.push_back({1'b0, (i == pld - 1) && !DIG, d});
         end
         if (DIG) expq.push_back({2'b01, x});
         mseq = (mseq + 1) % 4;
         som  = 1'b0;
         rem -= pld;
      end
   endtask

   task automatic cmp_out(input string tag);
      chk({tag, "_nbeats"}, 64'(gotq.size()), 64'(expq.size()));
      for (int i = 0; i < expq.size() && i < gotq.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), 64'(gotq[i]), 64'(expq[i]));
      gotq.delete();
      expq.delete();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!fcr_rdata[0]) break;
      end
      chk("idle", 64'(fcr_rdata[0]), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete();
      expq.delete();
      gotq.delete();
      mseq = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  dest, src;
      logic [15:0] tgt;
      logic [2:0]  tag;
      logic        to;
      bit          found;
      txdr_wr = 1'b0; fcr_wr = 1'b0; txdr_wdata = '0; fcr_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", 64'({tx_valid, tx_sop, tx_eop}), 64'd0);
      chk("rst_data", 64'(tx_data), 64'd0);
      chk("rst_fcr", fcr_rdata, 64'h4);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single TLP, first-beat latency
      for (int i = 0; i < 16; i++) push(32'h100 + i);
      chk("t1_cnt", 64'(fcr_rdata[41:32]), 64'(mq.size()));
      model_msg(16, 8'h08, 8'h09, 16'h1234, 3'd3, 1'b0);
      fcr_write(fcr(16, 8'h08, 8'h09, 16'h1234, 3'd3, 1'b0, 1'b0, 1'b1));
      chk("t1_lat1", 64'(tx_valid), 64'd0);
      @(posedge clk); #1;
      chk("t1_lat2", 64'({tx_valid, tx_sop}), 64'd3);
      wait_idle(200);
      cmp_out("t1");

      // Three-TLP message
      do_reset();
      for (int i = 0; i < 40; i++) push(32'h200 + i);
      model_msg(40, 8'h10, 8'h20, 16'hBEEF, 3'd5, 1'b1);
      fcr_write(fcr(40, 8'h10, 8'h20, 16'hBEEF, 3'd5, 1'b1, 1'b0, 1'b1));
      wait_idle(300);
      cmp_out("t2");
      chk("t2_cnt", 64'(fcr_rdata[41:32]), 64'd0);

      // Underrun, length errors, clear-then-go ordering
      for (int i = 0; i < 4; i++) push($urandom);
      fcr_write(fcr(10, 8'h1, 8'h2, 16'h3, 3'd1, 1'b0, 1'b0, 1'b1));
      repeat (6) @(posedge clk);
      #1;
      chk("t3_nobeat", 64'(gotq.size()), 64'd0);
      chk("t3_und", 64'(fcr_rdata[4]), 64'd1);
      chk("t3_cnt", 64'(fcr_rdata[41:32]), 64'd4);
      fcr_write(fcr(0, 8'h0, 8'h0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0));
      chk("t3_clr", 64'(fcr_rdata[6:3]), 64'd0);
      fcr_write(fcr(0, 8'h1, 8'h2, 16'h3, 3'd1, 1'b0, 1'b0, 1'b1));
      chk("t3_len0", 64'(fcr_rdata[3]), 64'd1);
      fcr_write(fcr(600, 8'h1, 8'h2, 16'h3, 3'd1, 1'b0, 1'b1, 1'b1));
      chk("t3_len600", 64'(fcr_rdata[3]), 64'd1);
      chk("t3_nobeat2", 64'(gotq.size()), 64'd0);
      model_msg(4, 8'h33, 8'h44, 16'h5566, 3'd7, 1'b0);
      fcr_write(fcr(4, 8'h33, 8'h44, 16'h5566, 3'd7, 1'b0, 1'b1, 1'b1));
      chk("t3_clrgo", 64'(fcr_rdata[3]), 64'd0);
      wait_idle(100);
      cmp_out("t3");

      // Random backpressure plus a go while busy
      for (int i = 0; i < 40; i++) push($urandom);
      dest = 8'($urandom); src = 8'($urandom); tgt = 16'($urandom);
      tag = 3'($urandom); to = 1'($urandom);
      model_msg(40, dest, src, tgt, tag, to);
      rand_rdy = 1'b1;
      fcr_write(fcr(40, dest, src, tgt, tag, to, 1'b0, 1'b1));
      repeat (8) @(posedge clk);
      #1;
      fcr_write(fcr(4, 8'h1, 8'h2, 16'h3, 3'd1, 1'b0, 1'b0, 1'b1));
      chk("t4_gobusy", 64'(fcr_rdata[6]), 64'd1);
      wait_idle(1000);
      rand_rdy = 1'b0;
      cmp_out("t4");
      chk("t4_cnt", 64'(fcr_rdata[41:32]), 64'd0);

      // Overflow
      do_reset();
      for (int i = 0; i < 512; i++) push(32'(i));
      chk("t5_full512", 64'({fcr_rdata[5], fcr_rdata[2:1]}), 64'b001);
      chk("t5_cnt512", 64'(fcr_rdata[41:32]), 64'(mq.size()));
      push(32'hDEAD_BEEF);
      chk("t5_ovf", 64'({fcr_rdata[5], fcr_rdata[2:1]}), 64'b101);
      chk("t5_cnt513", 64'(fcr_rdata[41:32]), 64'd512);

      // Reset during the second payload beat
      do_reset();
      for (int i = 0; i < 20; i++) push(32'hA000 + i);
      fcr_write(fcr(20, 8'h5, 8'h6, 16'h7, 3'd2, 1'b0, 1'b0, 1'b1));
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (tx_valid && tx_data == 32'hA001) found = 1'b1;
      end
      chk("t6_found", 64'(found), 64'd1);
      rst = 1'b1;
      #1;
      chk("t6_vld", 64'(tx_valid), 64'd0);
      chk("t6_cnt", 64'(fcr_rdata[41:32]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete(); expq.delete(); gotq.delete(); mseq = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) push($urandom);
      model_msg(4, 8'h5, 8'h6, 16'h7, 3'd2, 1'b0);
      fcr_write(fcr(4, 8'h5, 8'h6, 16'h7, 3'd2, 1'b0, 1'b0, 1'b1));
      wait_idle(100);
      cmp_out("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
